tmds_encoder_mc: RTL and testbench



---
 rtl/tmds_pkg.sv | 29 ++
 rtl/tmds_lane.sv | 144 ++++++++++++++
 rtl/tmds_encoder_mc.sv | 60 ++++++
 tb/tb_tmds_encoder_mc.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared types and code tables for the multi-channel TMDS encoder.
// All 10-bit symbols are stored MSB-first: bit 0 is transmitted first.
package tmds_pkg;

    typedef enum logic [1:0] {
        MODE_CTRL  = 2'd0,
        MODE_VIDEO = 2'd1,
        MODE_TERC4 = 2'd2,
        MODE_GUARD = 2'd3
    } mode_e;

    localparam int CNT_W = 5;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    localparam logic [9:0] GUARD_LANE1 = 10'b1100110010;
    localparam logic [9:0] GUARD_OTHER = 10'b0011001101;

    localparam logic [9:0] TERC4_TBL [16] = '{
        10'b0011100101, 10'b1100011001, 10'b0010011101, 10'b0100011101,
        10'b1000111010, 10'b0111100010, 10'b0111000110, 10'b0011110010,
        10'b0011001101, 10'b1001110010, 10'b0011100110, 10'b0110001101,
        10'b0111000101, 10'b1000111001, 10'b1100011010, 10'b1100001101
    };

endpackage

// File: rtl/tmds_lane.sv
// One TMDS lane: stage 1 builds q_m, stage 2 selects the symbol and tracks disparity.
// Latency 2 clk; no backpressure. TMDS_DISP_MON_EN adds the disparity monitor.
module tmds_lane
    import tmds_pkg::*;
#(
    parameter int LANE           = 0,
    parameter bit GUARD_DI_LANE0 = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  mode_e      mode_s1,
    input  logic [7:0] vd,
    input  logic [1:0] cd,
    input  logic [3:0] aux,
    output logic [9:0] tmds
`ifdef TMDS_DISP_MON_EN
    ,
    output logic       disp_err
`endif
);
    localparam int XW = CNT_W + 2;

    logic [8:0] qm_d, qm_q;
    logic [3:0] n1q_d, n1q_q;
    logic [1:0] cd_d, cd_q;
    logic [3:0] aux_d, aux_q;
    logic [3:0] n1;
    logic       xnor_sel, acc;

    always_comb begin
        n1 = '0;
        for (int k = 0; k < 8; k++) n1 = n1 + {3'b000, vd[k]};
        xnor_sel = (n1 > 4'd4) || ((n1 == 4'd4) && !vd[0]);
        qm_d = '0;
        acc = vd[0];
        qm_d[0] = acc;
        for (int k = 1; k < 8; k++) begin
            acc = xnor_sel ? ~(acc ^ vd[k]) : (acc ^ vd[k]);
            qm_d[k] = acc;
        end
        qm_d[8] = ~xnor_sel;
        n1q_d = '0;
        for (int k = 0; k < 8; k++) n1q_d = n1q_d + {3'b000, qm_d[k]};
        cd_d  = cd;
        aux_d = aux;
    end

    logic [9:0]              tmds_d, tmds_q;
    logic signed [CNT_W-1:0] cnt_d, cnt_q;
    logic signed [XW-1:0]    cnt_ext, diff, cnt_nx, qm8x2, nqm8x2;

    // Disparity arithmetic is done two bits wider so the out-of-range check sees true values.
    always_comb begin
        cnt_ext = {{2{cnt_q[CNT_W-1]}}, cnt_q};
        diff    = XW'({n1q_q, 1'b0}) - XW'(8);
        qm8x2   = XW'({qm_q[8], 1'b0});
        nqm8x2  = XW'({~qm_q[8], 1'b0});
        tmds_d  = CTRL_00;
        cnt_nx  = '0;
        case (mode_s1)
            MODE_VIDEO: begin
                if ((cnt_q == '0) || (n1q_q == 4'd4)) begin
                    tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                    cnt_nx = qm_q[8] ? (cnt_ext + diff) : (cnt_ext - diff);
                end else if ((!cnt_q[CNT_W-1] && (n1q_q > 4'd4)) ||
                             (cnt_q[CNT_W-1] && (n1q_q < 4'd4))) begin
                    tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                    cnt_nx = cnt_ext + qm8x2 - diff;
                end else begin
                    tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
                    cnt_nx = cnt_ext + diff - nqm8x2;
                end
            end
            MODE_TERC4: tmds_d = TERC4_TBL[aux_q];
            MODE_GUARD: begin
                if (GUARD_DI_LANE0 && (LANE == 0)) tmds_d = TERC4_TBL[aux_q];
                else if ((LANE % 3) == 1)          tmds_d = GUARD_LANE1;
                else                               tmds_d = GUARD_OTHER;
            end
            default: begin
                case (cd_q)
                    2'b00:   tmds_d = CTRL_00;
                    2'b01:   tmds_d = CTRL_01;
                    2'b10:   tmds_d = CTRL_10;
                    default: tmds_d = CTRL_11;
                endcase
            end
        endcase
        cnt_d = cnt_nx[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qm_q   <= '0;
            n1q_q  <= '0;
            cd_q   <= '0;
            aux_q  <= '0;
            tmds_q <= CTRL_00;
            cnt_q  <= '0;
        end else begin
            qm_q   <= qm_d;
            n1q_q  <= n1q_d;
            cd_q   <= cd_d;
            aux_q  <= aux_d;
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tmds = tmds_q;

`ifdef TMDS_DISP_MON_EN
    logic signed [5:0]    mon_d, mon_q;
    logic signed [XW-1:0] mon_nx;
    logic [3:0]           ones;
    logic                 err_d, err_q;

    always_comb begin
        ones = '0;
        for (int k = 0; k < 10; k++) ones = ones + {3'b000, tmds_d[k]};
        mon_nx = '0;
        err_d  = err_q;
        if (mode_s1 == MODE_VIDEO) begin
            mon_nx = {{(XW-6){mon_q[5]}}, mon_q} + XW'({ones, 1'b0}) - XW'(10);
            err_d  = err_q | (mon_nx > XW'(10)) | (mon_nx < -XW'(10)) |
                     (cnt_nx > XW'(8)) | (cnt_nx < -XW'(8));
        end
        mon_d = mon_nx[5:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mon_q <= '0;
            err_q <= 1'b0;
        end else begin
            mon_q <= mon_d;
            err_q <= err_d;
        end
    end

    assign disp_err = err_q;
`endif

endmodule

// File: rtl/tmds_encoder_mc.sv
// CH-lane TMDS/HDMI encoder (control, video, TERC4, guard); TMDS_DISP_MON_EN adds disp_err.
// Latency 2 clk; fully pipelined, no backpressure.
module tmds_encoder_mc
    import tmds_pkg::*;
#(
    parameter int CH             = 3,
    parameter bit GUARD_DI_LANE0 = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [8*CH-1:0]   vd,
    input  logic [2*CH-1:0]   cd,
    input  logic [4*CH-1:0]   aux,
    output logic [10*CH-1:0]  tmds,
    output logic [1:0]        mode_o
`ifdef TMDS_DISP_MON_EN
    ,
    output logic [CH-1:0]     disp_err
`endif
);
    mode_e mode_s1_d, mode_s1_q, mode_o_d, mode_o_q;

    always_comb begin
        mode_s1_d = mode_e'(mode);
        mode_o_d  = mode_s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_s1_q <= MODE_CTRL;
            mode_o_q  <= MODE_CTRL;
        end else begin
            mode_s1_q <= mode_s1_d;
            mode_o_q  <= mode_o_d;
        end
    end

    assign mode_o = mode_o_q;

    for (genvar i = 0; i < CH; i++) begin : g_lane
        tmds_lane #(
            .LANE           (i),
            .GUARD_DI_LANE0 (GUARD_DI_LANE0)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .mode_s1  (mode_s1_q),
            .vd       (vd[8*i +: 8]),
            .cd       (cd[2*i +: 2]),
            .aux      (aux[4*i +: 4]),
            .tmds     (tmds[10*i +: 10])
`ifdef TMDS_DISP_MON_EN
            ,
            .disp_err (disp_err[i])
`endif
        );
    end

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Directed bench for tmds_encoder_mc (CH=3, GUARD_DI_LANE0=1); tables written bit0..bit9.
module tb_tmds_encoder_mc;
    localparam int CH = 3;

    localparam logic [9:0] CTRL_SPEC [4] = '{
        10'b0010101011, 10'b1101010100, 10'b0010101010, 10'b1101010101
    };
    localparam logic [9:0] TERC_SPEC [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };
    localparam logic [9:0] GUARD1_SPEC = 10'b0100110011;
    localparam logic [9:0] GUARD0_SPEC = 10'b1011001100;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        mode;
    logic [8*CH-1:0]   vd;
    logic [2*CH-1:0]   cd;
    logic [4*CH-1:0]   aux;
    logic [10*CH-1:0]  tmds;
    logic [1:0]        mode_o;
`ifdef TMDS_DISP_MON_EN
    logic [CH-1:0]     disp_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int model_cnt [CH];

    tmds_encoder_mc #(.CH(CH), .GUARD_DI_LANE0(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .vd       (vd),
        .cd       (cd),
        .aux      (aux),
        .tmds     (tmds),
        .mode_o   (mode_o)
`ifdef TMDS_DISP_MON_EN
        ,
        .disp_err (disp_err)
`endif
    );

    always #5 clk = ~clk;

    // Table text is bit0 first; flip into a bit-indexed vector.
    function automatic logic [9:0] rev(input logic [9:0] s);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = s[9-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic [7:0] v, input logic [1:0] c, input logic [3:0] a);
        mode = m;
        vd   = {CH{v}};
        cd   = {CH{c}};
        aux  = {CH{a}};
    endtask

    task automatic ref_sym(input int ln, input logic [1:0] m, input logic [7:0] d,
                           input logic [1:0] c, input logic [3:0] a, output logic [9:0] s);
        logic [8:0] qm;
        int n1d, n1, n0;
        bit use_xnor;
        s = '0;
        case (m)
            2'd0: begin s = rev(CTRL_SPEC[c]); model_cnt[ln] = 0; end
            2'd2: begin s = rev(TERC_SPEC[a]); model_cnt[ln] = 0; end
            2'd3: begin
                if (ln == 0)          s = rev(TERC_SPEC[a]);
                else if (ln % 3 == 1) s = rev(GUARD1_SPEC);
                else                  s = rev(GUARD0_SPEC);
                model_cnt[ln] = 0;
            end
            default: begin
                n1d = $countones(d);
                use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
                qm[0] = d[0];
                for (int k = 1; k < 8; k++) qm[k] = use_xnor ? (qm[k-1] ~^ d[k]) : (qm[k-1] ^ d[k]);
                qm[8] = !use_xnor;
                n1 = $countones(qm[7:0]);
                n0 = 8 - n1;
                if (model_cnt[ln] == 0 || n1 == n0) begin
                    s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                    if (qm[8]) model_cnt[ln] += n1 - n0;
                    else       model_cnt[ln] += n0 - n1;
                end else if ((model_cnt[ln] > 0 && n1 > n0) || (model_cnt[ln] < 0 && n0 > n1)) begin
                    s = {1'b1, qm[8], ~qm[7:0]};
                    model_cnt[ln] += 2 * int'(qm[8]) + n0 - n1;
                end else begin
                    s = {1'b0, qm[8], qm[7:0]};
                    model_cnt[ln] += n1 - n0 - 2 * int'(!qm[8]);
                end
            end
        endcase
    endtask

    task automatic test_reset();
        logic [10*CH-1:0] exp_rst;
        exp_rst = {CH{rev(CTRL_SPEC[0])}};
        rst = 1'b1;
        drive(2'd0, 8'h00, 2'b00, 4'h0);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) rst = 1'b0;
            tick();
            n_cmp++;
            if (tmds !== exp_rst || mode_o !== 2'd0) begin
                n_bad++;
                $display("FAIL reset cyc=%0d tmds=%h mode_o=%0d want tmds=%h mode_o=0", i, tmds, mode_o, exp_rst);
            end
        end
        drive(2'd1, 8'hAA, 2'b00, 4'h0);
        tick();
        drive(2'd2, 8'h00, 2'b00, 4'h5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(2'd0, 8'h00, 2'b00, 4'h0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (tmds !== exp_rst || mode_o !== 2'd0) begin
                n_bad++;
                $display("FAIL reset_mid cyc=%0d tmds=%h mode_o=%0d want tmds=%h mode_o=0", i, tmds, mode_o, exp_rst);
            end
            tick();
        end
    endtask

    task automatic test_video_const();
        logic [1:0] vm [9];
        logic [7:0] vv [9];
        logic [9:0] ve [9];
        vm = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
        vv = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        ve = '{10'h100, 10'h3FF, 10'h100, 10'h3FF, rev(CTRL_SPEC[0]),
               10'h200, 10'h0FF, 10'h0FF, 10'h200};
        for (int j = 0; j <= 9; j++) begin
            if (j < 9) drive(vm[j], vv[j], 2'b00, 4'h0);
            else       drive(2'd0, 8'h00, 2'b00, 4'h0);
            tick();
            if (j >= 1) begin
                n_cmp++;
                if (tmds !== {CH{ve[j-1]}} || mode_o !== vm[j-1]) begin
                    n_bad++;
                    $display("FAIL video_const sym=%0d tmds=%h mode_o=%0d want tmds=%h mode_o=%0d",
                             j-1, tmds, mode_o, {CH{ve[j-1]}}, vm[j-1]);
                end
            end
        end
    endtask

    task automatic test_mode_switch();
        logic [1:0] vm [3];
        logic [1:0] vc [3];
        logic [9:0] ve [3];
        vm = '{2'd1, 2'd0, 2'd1};
        vc = '{2'b00, 2'b01, 2'b00};
        ve = '{10'h100, rev(CTRL_SPEC[1]), 10'h100};
        for (int j = 0; j <= 3; j++) begin
            if (j < 3) drive(vm[j], 8'h00, vc[j], 4'h0);
            else       drive(2'd0, 8'h00, 2'b00, 4'h0);
            tick();
            if (j >= 1) begin
                n_cmp++;
                if (tmds !== {CH{ve[j-1]}} || mode_o !== vm[j-1]) begin
                    n_bad++;
                    $display("FAIL mode_switch sym=%0d tmds=%h mode_o=%0d want tmds=%h mode_o=%0d",
                             j-1, tmds, mode_o, {CH{ve[j-1]}}, vm[j-1]);
                end
            end
        end
    endtask

    task automatic test_terc4();
        logic [10*CH-1:0] e;
        for (int j = 0; j <= 16; j++) begin
            if (j < 16) begin
                mode = 2'd2;
                for (int i = 0; i < CH; i++) aux[4*i +: 4] = 4'((j + i) % 16);
            end else begin
                drive(2'd0, 8'h00, 2'b00, 4'h0);
            end
            tick();
            if (j >= 1) begin
                for (int i = 0; i < CH; i++) e[10*i +: 10] = rev(TERC_SPEC[(j - 1 + i) % 16]);
                n_cmp++;
                if (tmds !== e || mode_o !== 2'd2) begin
                    n_bad++;
                    $display("FAIL terc4 step=%0d tmds=%h mode_o=%0d want tmds=%h mode_o=2", j-1, tmds, mode_o, e);
                end
            end
        end
    endtask

    task automatic test_guard();
        logic [9:0] e [3];
        e = '{rev(10'b1010001110), rev(GUARD1_SPEC), rev(GUARD0_SPEC)};
        mode = 2'd3;
        vd   = 24'h5A3C81;
        cd   = 6'b100111;
        aux  = {4'h9, 4'h5, 4'hC};
        tick();
        drive(2'd0, 8'h00, 2'b00, 4'h0);
        tick();
        for (int i = 0; i < CH; i++) begin
            n_cmp++;
            if (tmds[10*i +: 10] !== e[i] || mode_o !== 2'd3) begin
                n_bad++;
                $display("FAIL guard lane=%0d sym=%b mode_o=%0d want sym=%b mode_o=3", i, tmds[10*i +: 10], mode_o, e[i]);
            end
        end
    endtask

    task automatic test_random(input int n, input bit video_only);
        logic [10*CH-1:0] eq [$];
        logic [1:0]       mq [$];
        logic [10*CH-1:0] e;
        logic [1:0]       m;
        logic [9:0]       s;
        int cum [CH];
        int worst;
        worst = 0;
        for (int i = 0; i < CH; i++) begin
            model_cnt[i] = 0;
            cum[i] = 0;
        end
        for (int j = 0; j <= n; j++) begin
            if (j < n) begin
                m    = video_only ? 2'd1 : 2'($urandom_range(0, 3));
                mode = m;
                vd   = (8*CH)'($urandom);
                cd   = (2*CH)'($urandom);
                aux  = (4*CH)'($urandom);
                for (int i = 0; i < CH; i++) begin
                    ref_sym(i, m, vd[8*i +: 8], cd[2*i +: 2], aux[4*i +: 4], s);
                    e[10*i +: 10] = s;
                end
                eq.push_back(e);
                mq.push_back(m);
            end else begin
                drive(2'd0, 8'h00, 2'b00, 4'h0);
            end
            tick();
            if (j >= 1) begin
                e = eq.pop_front();
                m = mq.pop_front();
                n_cmp++;
                if (tmds !== e || mode_o !== m) begin
                    n_bad++;
                    $display("FAIL random sym=%0d tmds=%h mode_o=%0d want tmds=%h mode_o=%0d", j-1, tmds, mode_o, e, m);
                end
                if (video_only) begin
                    for (int i = 0; i < CH; i++) begin
                        cum[i] += 2 * $countones(tmds[10*i +: 10]) - 10;
                        if (cum[i] > worst)  worst = cum[i];
                        if (-cum[i] > worst) worst = -cum[i];
                    end
                end
            end
        end
        if (video_only) begin
            n_cmp++;
            if (worst > 10) begin
                n_bad++;
                $display("FAIL dc_balance worst |ones-zeros|=%0d want <=10", worst);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(2'd0, 8'h00, 2'b00, 4'h0);
        test_reset();
        test_video_const();
        test_mode_switch();
        test_terc4();
        test_guard();
        test_random(1500, 1'b1);
        test_random(1000, 1'b0);
`ifdef TMDS_DISP_MON_EN
        n_cmp++;
        if (disp_err !== '0) begin
            n_bad++;
            $display("FAIL disp_err got=%b want=0", disp_err);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
